// File: rtl/tft_frame_scheduler.sv
// Drives one TFT window write: CASET, PASET, RAMWR header followed by the pixel stream.
// Owns cs_n and the RS line for the whole transaction so no other requester can interleave.
module tft_frame_scheduler #(
    parameter logic [7:0] CMD_CASET = 8'h2A,
    parameter logic [7:0] CMD_PASET = 8'h2B,
    parameter logic [7:0] CMD_RAMWR = 8'h2C,
    parameter int         WIDTH     = 240,
    parameter int         HEIGHT    = 320,
    parameter int         CNT_BITS  = 17
) (
    input  logic        MasterCLK,
    input  logic        reset,
    input  logic        init_done,
    input  logic        start,
    input  logic [8:0]  x0,
    input  logic [8:0]  x1,
    input  logic [8:0]  y0,
    input  logic [8:0]  y1,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  tx_data,
    output logic        tx_rs,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        cs_n
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] CASET_C  = 4'd1;
    localparam logic [3:0] CASET_D  = 4'd2;
    localparam logic [3:0] PASET_C  = 4'd3;
    localparam logic [3:0] PASET_D  = 4'd4;
    localparam logic [3:0] RAMWR_C  = 4'd5;
    localparam logic [3:0] PIX_LOAD = 4'd6;
    localparam logic [3:0] PIX_HI   = 4'd7;
    localparam logic [3:0] PIX_LO   = 4'd8;
    localparam logic [3:0] DONE     = 4'd9;

    localparam logic [8:0]          X_LIMIT = 9'(WIDTH);
    localparam logic [8:0]          Y_LIMIT = 9'(HEIGHT);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    logic [3:0]          state, next_state;
    logic [1:0]          byte_idx, next_idx;
    logic [CNT_BITS-1:0] cnt, next_cnt;
    logic [15:0]         pix, next_pix;
    logic [8:0]          win_x0, win_x1, win_y0, win_y1;

    logic                win_ok;
    logic [8:0]          span_x, span_y;
    logic [CNT_BITS-1:0] area;
    logic                fire;
    logic                accept, reject;

    logic                nxt_valid, nxt_rs;
    logic [7:0]          nxt_data;

    // Byte sequence for a 9-bit start/end pair: high byte carries only bit 8.
    function automatic logic [7:0] coord_byte(input logic [1:0] idx,
                                              input logic [8:0] lo,
                                              input logic [8:0] hi);
        case (idx)
            2'd0:    coord_byte = {7'b0, lo[8]};
            2'd1:    coord_byte = lo[7:0];
            2'd2:    coord_byte = {7'b0, hi[8]};
            default: coord_byte = hi[7:0];
        endcase
    endfunction

    assign win_ok = (x0 <= x1) && (x1 < X_LIMIT) && (y0 <= y1) && (y1 < Y_LIMIT);
    assign span_x = x1 - x0 + 9'd1;
    assign span_y = y1 - y0 + 9'd1;
    assign area   = CNT_BITS'(span_x) * CNT_BITS'(span_y);
    assign fire   = tx_valid && tx_ready;

    // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
    always_comb begin
        next_state = state;
        next_idx   = byte_idx;
        next_cnt   = cnt;
        next_pix   = pix;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (start && init_done) begin
                    if (win_ok) begin
                        accept     = 1'b1;
                        next_cnt   = area;
                        next_state = CASET_C;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            CASET_C: if (fire) begin
                next_state = CASET_D;
                next_idx   = 2'd0;
            end
            CASET_D: if (fire) begin
                if (byte_idx == 2'd3) next_state = PASET_C;
                else                  next_idx   = byte_idx + 2'd1;
            end
            PASET_C: if (fire) begin
                next_state = PASET_D;
                next_idx   = 2'd0;
            end
            PASET_D: if (fire) begin
                if (byte_idx == 2'd3) next_state = RAMWR_C;
                else                  next_idx   = byte_idx + 2'd1;
            end
            RAMWR_C: if (fire) next_state = PIX_LOAD;
            PIX_LOAD: if (pix_valid) begin
                next_pix   = pix_data;
                next_state = PIX_HI;
            end
            PIX_HI: if (fire) next_state = PIX_LO;
            PIX_LO: if (fire) begin
                next_cnt   = cnt - CNT_ONE;
                next_state = (cnt == CNT_ONE) ? DONE : PIX_LOAD;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in the state they describe.
    always_comb begin
        nxt_valid = 1'b1;
        nxt_rs    = 1'b1;
        nxt_data  = 8'h00;
        case (next_state)
            CASET_C: begin nxt_rs = 1'b0; nxt_data = CMD_CASET; end
            CASET_D: nxt_data = coord_byte(next_idx, win_x0, win_x1);
            PASET_C: begin nxt_rs = 1'b0; nxt_data = CMD_PASET; end
            PASET_D: nxt_data = coord_byte(next_idx, win_y0, win_y1);
            RAMWR_C: begin nxt_rs = 1'b0; nxt_data = CMD_RAMWR; end
            PIX_HI:  nxt_data = next_pix[15:8];
            PIX_LO:  nxt_data = next_pix[7:0];
            default: begin nxt_valid = 1'b0; nxt_rs = 1'b0; end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge MasterCLK) begin
        if (reset) begin
            state     <= IDLE;
            byte_idx  <= 2'd0;
            cnt       <= '0;
            pix       <= 16'h0000;
            win_x0    <= 9'd0;
            win_x1    <= 9'd0;
            win_y0    <= 9'd0;
            win_y1    <= 9'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            pix_ready <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            tx_rs     <= 1'b0;
            cs_n      <= 1'b1;
        end else begin
            state     <= next_state;
            byte_idx  <= next_idx;
            cnt       <= next_cnt;
            pix       <= next_pix;
            if (accept) begin
                win_x0 <= x0;
                win_x1 <= x1;
                win_y0 <= y0;
                win_y1 <= y1;
            end
            busy      <= (next_state != IDLE);
            done      <= (next_state == DONE);
            error     <= reject;
            pix_ready <= (next_state == PIX_LOAD);
            tx_valid  <= nxt_valid;
            tx_data   <= nxt_data;
            tx_rs     <= nxt_rs;
            cs_n      <= (next_state == IDLE) || (next_state == DONE);
        end
    end

endmodule
